// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester APB master with round-robin arbitration,
// SETUP/ACCESS sequencing and an ACCESS-phase timeout guard.
module apb_rr_master #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          any_req;
  logic          pick1;
  logic          fin;
  logic          fin_err;
  logic [DW-1:0] fin_rdata;

  // Round-robin pick: with both valid, the one not granted last wins
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick1   = req1_valid & (~req0_valid | ~last_q);
  end

  // Next-state, bus phase and requester response logic
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;

    unique case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (any_req) begin
          grant_d  = pick1;
          last_d   = pick1;
          pwrite_d = pick1 ? req1_write : req0_write;
          paddr_d  = pick1 ? req1_addr  : req0_addr;
          pwdata_d = pick1 ? req1_wdata : req0_wdata;
          ack0_d   = ~pick1;
          ack1_d   = pick1;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          fin       = 1'b1;
          fin_err   = pslverr;
          fin_rdata = pwrite_q ? '0 : prdata;
        end else if (cnt_q == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (fin) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    done0_d  = fin & ~grant_q;
    done1_d  = fin & grant_q;
    err0_d   = done0_d & fin_err;
    err1_d   = done1_d & fin_err;
    rdata0_d = done0_d ? fin_rdata : '0;
    rdata1_d = done1_d ? fin_rdata : '0;
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign req0_ack   = ack0_q;
  assign req1_ack   = ack1_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed vectors and hand sequences for apb_rr_master,
// with a memory-backed APB slave of configurable wait states and error.
module tb_apb_rr_master;

  logic            pclk = 1'b0;
  logic            prst = 1'b0;
  logic [1:0]      v = '0;
  logic [1:0]      w = '0;
  logic [1:0][7:0] a = '0;
  logic [1:0][7:0] wd = '0;
  logic [1:0]      ack;
  logic [1:0]      done;
  logic [1:0]      errs;
  logic [1:0][7:0] rd;
  logic            psel, penable, pwrite;
  logic [7:0]      paddr, pwdata;
  logic [7:0]      prdata = '0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;

  int   tests = 0;
  int   fails = 0;
  int   wait_cfg = 0;
  logic err_cfg = 1'b0;
  int   acc_cnt = 0;
  logic [7:0] mem [256] = '{default: 8'h00};

  apb_rr_master dut (
    .pclk(pclk), .prst(prst),
    .req0_valid(v[0]), .req0_write(w[0]),
    .req0_addr(a[0]), .req0_wdata(wd[0]),
    .req0_ack(ack[0]), .req0_done(done[0]),
    .req0_rdata(rd[0]), .req0_err(errs[0]),
    .req1_valid(v[1]), .req1_write(w[1]),
    .req1_addr(a[1]), .req1_wdata(wd[1]),
    .req1_ack(ack[1]), .req1_done(done[1]),
    .req1_rdata(rd[1]), .req1_err(errs[1]),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave: answers after wait_cfg ACCESS cycles; errored writes do not land
  always @(negedge pclk) begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 8'h00;
    if (psel && penable) begin
      if (acc_cnt >= wait_cfg) begin
        pready  = 1'b1;
        pslverr = err_cfg;
        if (!pwrite) prdata = mem[paddr];
        else if (!err_cfg) mem[paddr] = pwdata;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int id, input logic wr, input logic [7:0] ad,
                      input logic [7:0] wdat, output logic got,
                      output logic [7:0] rdo, output logic erro,
                      output int acc, output logic clean);
    int   oth;
    logic acked;
    oth = 1 - id;
    got = 0; rdo = 0; erro = 0; acc = 0; clean = 1; acked = 0;
    @(negedge pclk);
    v[id] = 1'b1; w[id] = wr; a[id] = ad; wd[id] = wdat;
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (ack[id]) begin acked = 1; break; end
    end
    v[id] = 1'b0;
    if (acked) begin
      for (int i = 0; i < 300; i++) begin
        @(posedge pclk); #1;
        if (psel && penable) acc++;
        if (ack[oth] || done[oth] || errs[oth] || rd[oth] != 0 || ack[id])
          clean = 0;
        if (!done[id] && (rd[id] != 0 || errs[id])) clean = 0;
        if (done[id]) begin
          got = 1; rdo = rd[id]; erro = errs[id];
          if (psel || penable) clean = 0;
          break;
        end
      end
    end
  endtask

  task automatic pair(input int wid, input logic [7:0] ad,
                      input logic [7:0] d, output int first,
                      output int ndone, output logic [7:0] rdr);
    int rid;
    rid = 1 - wid;
    first = -1; ndone = 0; rdr = 0;
    @(negedge pclk);
    v = 2'b11;
    w[wid] = 1'b1; w[rid] = 1'b0;
    a[wid] = ad; a[rid] = ad;
    wd[wid] = d; wd[rid] = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(posedge pclk); #1;
      for (int j = 0; j < 2; j++) begin
        if (ack[j]) begin
          if (first < 0) first = j;
          v[j] = 1'b0;
        end
        if (done[j]) begin
          ndone++;
          if (j == rid) rdr = rd[j];
        end
      end
      if (ndone == 2) break;
    end
    v = 2'b00;
  endtask

  typedef struct {
    int         id;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wt;
    logic       serr;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_acc;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic       got, erro, clean;
    logic [7:0] rdo;
    int         acc, first, ndone;

    tbl[0] = '{1, 1'b0, 8'h05, 8'h00,   0, 1'b0, 1'b0, 8'hA5,  1};
    tbl[1] = '{0, 1'b1, 8'hC9, 8'h33,   0, 1'b1, 1'b1, 8'h00,  1};
    tbl[2] = '{1, 1'b0, 8'hC9, 8'h00,   0, 1'b0, 1'b0, 8'h00,  1};
    tbl[3] = '{0, 1'b1, 8'h20, 8'h5A,   3, 1'b0, 1'b0, 8'h00,  4};
    tbl[4] = '{1, 1'b0, 8'h20, 8'h00,   2, 1'b0, 1'b0, 8'h5A,  3};
    tbl[5] = '{0, 1'b0, 8'h20, 8'h00, 255, 1'b0, 1'b1, 8'h00, 16};
    tbl[6] = '{1, 1'b0, 8'h05, 8'h00,   0, 1'b0, 1'b0, 8'hA5,  1};
    tbl[7] = '{0, 1'b0, 8'h05, 8'h00,   1, 1'b1, 1'b1, 8'hA5,  2};

    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_bus", {pwrite, paddr, pwdata}, 0);
    check("rst_resp", {ack, done, errs, rd}, 0);
    @(negedge pclk);
    prst = 1'b1;

    // zero-wait write: psel at cycle 1, penable at 2, done at 3
    @(negedge pclk);
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 8'h05; wd[0] = 8'hA5;
    @(posedge pclk); #1;
    check("c1_psel_pen", {psel, penable}, 2'b10);
    check("c1_ack", ack, 2'b01);
    v[0] = 1'b0;
    @(posedge pclk); #1;
    check("c2_psel_pen", {psel, penable}, 2'b11);
    check("c2_bus", {pwrite, paddr, pwdata}, {1'b1, 8'h05, 8'hA5});
    @(posedge pclk); #1;
    check("c3_done", done, 2'b01);
    check("c3_resp", {errs[0], rd[0], psel}, 0);

    for (int k = 0; k < 8; k++) begin
      wait_cfg = tbl[k].wt;
      err_cfg  = tbl[k].serr;
      xfer(tbl[k].id, tbl[k].wr, tbl[k].addr, tbl[k].wdata,
           got, rdo, erro, acc, clean);
      check($sformatf("v%0d_done", k), got, 1);
      check($sformatf("v%0d_err", k), erro, tbl[k].exp_err);
      check($sformatf("v%0d_rdata", k), rdo, tbl[k].exp_rd);
      check($sformatf("v%0d_acc", k), acc, tbl[k].exp_acc);
      check($sformatf("v%0d_clean", k), clean, 1);
    end
    wait_cfg = 0;
    err_cfg  = 1'b0;

    // simultaneous pair right after reset: req0 first
    @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    prst = 1'b1;
    pair(0, 8'h10, 8'h77, first, ndone, rdo);
    check("p1_first", first, 0);
    check("p1_ndone", ndone, 2);
    check("p1_rdata", rdo, 8'h77);

    // req0 alone, then a pair must favour req1
    xfer(0, 1'b0, 8'h10, 8'h00, got, rdo, erro, acc, clean);
    check("s_rdata", rdo, 8'h77);
    pair(1, 8'h10, 8'h3C, first, ndone, rdo);
    check("p2_first", first, 1);
    check("p2_ndone", ndone, 2);
    check("p2_rdata", rdo, 8'h3C);

    // reset during ACCESS on a req0 transfer
    wait_cfg = 255;
    @(negedge pclk);
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 8'h05;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk); #1;
      if (ack[0]) v[0] = 1'b0;
      if (penable) begin got = 1; break; end
    end
    check("ra_access", got, 1);
    v[0] = 1'b0;
    repeat (3) @(posedge pclk);
    #2;
    prst = 1'b0;
    #1;
    check("ra_drop", {psel, penable}, 0);
    got = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      if (done != 0) got = 1;
    end
    check("ra_nodone", got, 0);
    @(negedge pclk);
    prst = 1'b1;
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      if (done != 0) got = 1;
    end
    check("ra_nodone2", got, 0);
    pair(0, 8'h30, 8'hE1, first, ndone, rdo);
    check("ra_first", first, 0);
    check("ra_ndone", ndone, 2);
    check("ra_rdata", rdo, 8'hE1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master that shares one APB slave port between requesters 0 and 1.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Waits for pready, with a timeout guard, then returns read data and an error status to the granted requester.
- Sits between on-chip initiators (test sequencers, config engines) and the peripheral register block.

Parameters:
- AW, 8, address width (paddr, reqN_addr).
- DW, 8, data width (pwdata, prdata, reqN_wdata, reqN_rdata).
- TIMEOUT, 16, maximum ACCESS cycles without pready before the transfer is aborted (legal range 2..255).

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- prst  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command; held until req0_ack.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  AW  target address.
- req0_wdata  in  DW  write data.
- req0_ack  out  1  one-cycle pulse: command accepted.
- req0_done  out  1  one-cycle pulse: transfer complete.
- req0_rdata  out  DW  read data; valid while req0_done = 1.
- req0_err  out  1  error status; valid while req0_done = 1.
- req1_*  (same six signals, same directions and widths, for requester 1).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset (prst = 0, asynchronous): state = IDLE; psel, penable, pwrite, paddr, pwdata, all ack/done/err/rdata = 0; wait counter = 0; last_grant = 1, so requester 0 wins the first contention.
- Reset mid-transfer aborts immediately. No done pulse is issued for the aborted command.
- State machine: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - psel = 0, penable = 0.
  - If any reqN_valid: choose the winner, latch write/addr/wdata into pwrite/paddr/pwdata, set grant, go to SETUP.
  - Registered reqN_ack = 1 for the winner in the SETUP cycle only.
- Arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on a grant.
  - Requests are never accepted outside IDLE. The losing requester keeps valid high and is served next.
- SETUP: psel = 1, penable = 0, for exactly one cycle; go to ACCESS; wait counter = 0.
- ACCESS: psel = 1, penable = 1; paddr, pwdata and pwrite are held stable.
  - pready = 1: capture response, go to IDLE. Next cycle: reqN_done = 1, reqN_err = pslverr, reqN_rdata = prdata for reads and 0 for writes.
  - pready = 0: increment the counter. When the counter reaches TIMEOUT-1 with pready still 0: go to IDLE, then reqN_done = 1, err = 1, rdata = 0.
- IDLE entry drives psel = 0 and penable = 0 in that same cycle.
- Latency with a zero-wait slave:
  - valid seen in IDLE at cycle 0.
  - psel = 1 at cycle 1 (SETUP).
  - penable = 1 at cycle 2.
  - done at cycle 3.
  - Next grant possible at cycle 3, so the minimum spacing between SETUP phases is 3 cycles.
- Outputs to the non-granted requester stay 0. The rdata/err of both requesters are 0 whenever done = 0.
- reqN_valid deasserted before ack: the command is ignored if seen low in IDLE. A deassertion after acceptance has no effect.
- pslverr is sampled only when pready = 1 in ACCESS.

Test Plan:
- Single write, requester 0, addr 0x05, wdata 0xA5, slave zero-wait -> psel at cycle 1, penable at cycle 2 with paddr 0x05 and pwdata 0xA5; req0_done at cycle 3, err = 0, rdata = 0x00.
- Readback, requester 1, addr 0x05 -> req1_done with req1_rdata = 0xA5, err = 0; requester 0 outputs stay 0.
- Both valid in the same cycle after reset: req0 write 0x10, req1 read 0x10 -> req0 granted first, req1 second; req1_rdata = req0 data. A second simultaneous pair grants req1 first.
- Slave error: write to addr 0xC9 where the slave returns pslverr = 1 -> req0_done with req0_err = 1, and the bus returns to IDLE.
- Timeout: slave holds pready = 0 -> exactly TIMEOUT (16) ACCESS cycles, then done with err = 1, rdata = 0; a later request proceeds normally.
- Reset asserted during ACCESS -> psel and penable drop immediately, no done pulse; after release, requester 0 has priority again.
